npu_layer_sequencer: RTL
========================

// Module: npu_layer_sequencer
// PURPOSE
//  Sequences the NPU LeNet datapath ALU through C1 -> S2 -> C3 -> S4 -> C5 on one start pulse.
//  Then issues LRMOVE cycles that copy the 8-bit result bytes into NPU registers.
//  Drives the ALU opcode bus, register write address and result-byte select.
//  Reports busy and done to the CPU-side control.
// PARAMETERS
//  OP_C1      8'h01  opcode for conv layer 1
//  OP_S2      8'h02  opcode for pool layer 2
//  OP_C3      8'h03  opcode for conv layer 3
//  OP_S4      8'h04  opcode for pool layer 4
//  OP_C5      8'h05  opcode for full-connection layer 5
//  OP_LRMOVE  8'h06  opcode for result-to-register move
//  OP_NOP     8'h00  idle opcode; the ALU decodes it as the default case
//  HOLD       4      cycles each layer opcode is held; legal range 1..15
//  RES_BYTES  10     result bytes to move; legal range 1..16
//  REG_BASE   5'd1   first destination register; REG_BASE+RES_BYTES-1 must be <= 31
// PORTS
//  clk_i              in   1  clock, rising edge
//  rst_i              in   1  asynchronous, active-low reset
//  start_i            in   1  1-cycle start request; ignored while busy_o=1
//  abort_i            in   1  synchronous abort; returns the block to IDLE
//  alu_o              out  8  opcode to the NPU ALU alu_i
//  w_reg_addr_npu_o   out  5  destination register for LRMOVE
//  res_sel_o          out  4  index of the result byte presented on the ALU result_i
//  layer_o            out  3  current phase: 0..4 = C1..C5, 5 = MOVE, 7 = idle
//  busy_o             out  1  1 from the cycle after start is accepted until done_o
//  done_o             out  1  1-cycle pulse when the whole sequence completes
// BEHAVIOUR
//  Reset (async, rst_i=0):
//   - Outputs: alu_o=OP_NOP, w_reg_addr_npu_o=0, res_sel_o=0, layer_o=7, busy_o=0, done_o=0.
//   - State=IDLE and all counters=0. A reset mid-sequence abandons the run with no done_o.
//  All outputs are registered.
//  FSM states: IDLE, RUN, GAP, MOVE, DONE.
//  IDLE:
//   - start_i=1 at edge k -> RUN, layer=0.
//   - alu_o=OP_C1 from cycle k+1.
//  RUN:
//   - alu_o holds the layer opcode for exactly HOLD cycles; hold counter counts 0..HOLD-1.
//   - Then GAP.
//  GAP:
//   - One cycle of alu_o=OP_NOP; this separates layer writes so the ALU en_w drops.
//   - If layer<4: layer+1, back to RUN.
//   - Else: MOVE with byte index=0.
//  MOVE:
//   - alu_o=OP_LRMOVE, res_sel_o=idx, w_reg_addr_npu_o=REG_BASE+idx (5-bit, no wrap allowed).
//   - idx increments every cycle for RES_BYTES cycles, then DONE.
//  DONE:
//   - One cycle: alu_o=OP_NOP, done_o=1, busy_o=0, layer_o=7.
//   - Next state is IDLE.
//   - start_i in this cycle is accepted (back-to-back runs).
//  Timing, start sampled at edge k (defaults):
//   - Layer i opcode occupies cycles k+1+i*(HOLD+1) .. k+i*(HOLD+1)+HOLD.
//   - MOVE occupies k+1+5*(HOLD+1) .. k+5*(HOLD+1)+RES_BYTES.
//   - done_o is high at k+1+5*(HOLD+1)+RES_BYTES, i.e. 36 cycles after start.
//  start_i while busy (RUN/GAP/MOVE): ignored, no queueing.
//  abort_i:
//   - In any non-IDLE state: next cycle is IDLE with reset output values; no done_o.
//   - abort_i has priority over start_i in the same cycle.
//   - abort_i in IDLE is a no-op.
//  res_sel_o and w_reg_addr_npu_o hold their last MOVE values until the next MOVE or reset.
//   - Exception: abort and reset clear them.
// TESTING
//  1. Reset mid-C3 (rst_i low 3 cycles) -> all outputs at reset values immediately.
//     Then IDLE; no done_o.
//  2. Single start, defaults -> alu_o sequence 01x4,00,02x4,00,03x4,00,04x4,00,05x4,00,06x10.
//     done_o at cycle 36; busy_o high for cycles 1..35.
//  3. MOVE phase -> w_reg_addr_npu_o steps 1..10 and res_sel_o steps 0..9 in lockstep
//     with alu_o=06.
//  4. start_i pulsed at cycles 5 and 20 of a run -> ignored.
//     Exactly one done_o, at cycle 36.
//  5. abort_i at cycle 12 (in C3) -> alu_o=00, busy_o=0, layer_o=7 at cycle 13; no done_o.
//     A new start then runs the full sequence.
//  6. start_i asserted in the DONE cycle; also HOLD=1, RES_BYTES=1 ->
//     second run begins next cycle, done_o 12 cycles later.

Source files
------------

// File: rtl/npu_layer_sequencer_if.sv
// Control/ALU-side bundle of the LeNet layer sequencer: start/abort in, opcode,
// register address, result-byte select and status out.
interface npu_layer_sequencer_if;
  logic       start_i;
  logic       abort_i;
  logic [7:0] alu_o;
  logic [4:0] w_reg_addr_npu_o;
  logic [3:0] res_sel_o;
  logic [2:0] layer_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, abort_i,
    input  alu_o, w_reg_addr_npu_o, res_sel_o, layer_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i,
    output alu_o, w_reg_addr_npu_o, res_sel_o, layer_o, busy_o, done_o
  );
endinterface

// File: rtl/npu_layer_sequencer.sv
// Steps the NPU ALU through C1..C5 with a NOP gap after each layer, then moves
// the result bytes into NPU registers with LRMOVE; every output is registered.
module npu_layer_sequencer #(
  parameter logic [7:0] OP_C1     = 8'h01,
  parameter logic [7:0] OP_S2     = 8'h02,
  parameter logic [7:0] OP_C3     = 8'h03,
  parameter logic [7:0] OP_S4     = 8'h04,
  parameter logic [7:0] OP_C5     = 8'h05,
  parameter logic [7:0] OP_LRMOVE = 8'h06,
  parameter logic [7:0] OP_NOP    = 8'h00,
  parameter int         HOLD      = 4,
  parameter int         RES_BYTES = 10,
  parameter logic [4:0] REG_BASE  = 5'd1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  npu_layer_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_MOVE,
    ST_DONE
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [3:0] IDX_LAST  = 4'(RES_BYTES - 1);
  localparam logic [2:0] LAYER_IDLE = 3'd7;
  localparam logic [2:0] LAYER_MOVE = 3'd5;

  state_e     state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] idx_q, idx_d;

  logic [7:0] alu_q, alu_d;
  logic [4:0] waddr_q, waddr_d;
  logic [3:0] sel_q, sel_d;
  logic [2:0] layer_out_q, layer_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      layer_q     <= 3'd0;
      hold_q      <= 4'd0;
      idx_q       <= 4'd0;
      alu_q       <= OP_NOP;
      waddr_q     <= 5'd0;
      sel_q       <= 4'd0;
      layer_out_q <= LAYER_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      alu_q       <= alu_d;
      waddr_q     <= waddr_d;
      sel_q       <= sel_d;
      layer_out_q <= layer_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state first, then the registered outputs are decoded from the state
  // being entered so they line up with it on the same edge.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    alu_d       = OP_NOP;
    waddr_d     = waddr_q;
    sel_d       = sel_q;
    layer_out_d = LAYER_IDLE;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    if (bus.abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      layer_d = 3'd0;
      hold_d  = 4'd0;
      idx_d   = 4'd0;
      waddr_d = 5'd0;
      sel_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start_i) begin
            state_d = ST_RUN;
            layer_d = 3'd0;
            hold_d  = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_GAP;
            hold_d  = 4'd0;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        ST_GAP: begin
          if (layer_q < 3'd4) begin
            state_d = ST_RUN;
            layer_d = layer_q + 3'd1;
            hold_d  = 4'd0;
          end else begin
            state_d = ST_MOVE;
            idx_d   = 4'd0;
          end
        end
        ST_MOVE: begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            idx_d   = 4'd0;
            layer_d = 3'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    case (state_d)
      ST_RUN: begin
        busy_d      = 1'b1;
        layer_out_d = layer_d;
        case (layer_d)
          3'd0:    alu_d = OP_C1;
          3'd1:    alu_d = OP_S2;
          3'd2:    alu_d = OP_C3;
          3'd3:    alu_d = OP_S4;
          default: alu_d = OP_C5;
        endcase
      end
      ST_GAP: begin
        busy_d      = 1'b1;
        layer_out_d = layer_d;
      end
      ST_MOVE: begin
        busy_d      = 1'b1;
        layer_out_d = LAYER_MOVE;
        alu_d       = OP_LRMOVE;
        sel_d       = idx_d;
        waddr_d     = REG_BASE + {1'b0, idx_d};
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_o            = alu_q;
  assign bus.w_reg_addr_npu_o = waddr_q;
  assign bus.res_sel_o        = sel_q;
  assign bus.layer_o          = layer_out_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;

endmodule
